// File: rtl/friscv_bus_perf_mon_if.sv
// Monitored valid/ready channels plus the shadow-bank read port of friscv_bus_perf_mon.
interface friscv_bus_perf_mon_if #(
  parameter int REG_W  = 32,
  parameter int NB_BUS = 2
);
  localparam int AW = $clog2(NB_BUS) + 2;

  logic [NB_BUS-1:0] valid;
  logic [NB_BUS-1:0] ready;
  logic              rd_en;
  logic [AW-1:0]     rd_addr;
  logic [REG_W-1:0]  rd_data;
  logic              rd_valid;
  logic [NB_BUS-1:0] overflow;

  modport master (output valid, ready, rd_en, rd_addr, input rd_data, rd_valid, overflow);
  modport slave  (input valid, ready, rd_en, rd_addr, output rd_data, rd_valid, overflow);
endinterface

// File: rtl/friscv_bus_perf_mon.sv
// Per-channel active/stall/idle counters with snapshot shadow bank and 1-cycle read port.
// Optional maximum stall-run tracking is enabled by defining FRISCV_PERF_MAX_STALL_EN.
module friscv_bus_perf_mon #(
  parameter int REG_W    = 32,
  parameter int NB_BUS   = 2,
  parameter int SATURATE = 1
) (
  input  logic                aclk,
  input  logic                aresetn,
  input  logic                srst,
  input  logic                enable,
  input  logic                snap,
  friscv_bus_perf_mon_if.slave bus
);

  localparam int AW = $clog2(NB_BUS) + 2;

  // Returns {overflow, next value}; saturates or wraps at all-ones.
  function automatic logic [REG_W:0] cnt_inc(input logic [REG_W-1:0] v, input logic en);
    logic [REG_W:0] r;
    if (!en) begin
      r = {1'b0, v};
    end else if (&v) begin
      r = {1'b1, (SATURATE != 0) ? v : {REG_W{1'b0}}};
    end else begin
      r = {1'b0, v + REG_W'(1)};
    end
    return r;
  endfunction

  logic [NB_BUS-1:0] hs_s, st_s, id_s;
  logic [NB_BUS-1:0] armed_r, ovf_r, ovf_nx_s, run_ovf_s;
  logic [REG_W-1:0]  act_r [NB_BUS];
  logic [REG_W-1:0]  stl_r [NB_BUS];
  logic [REG_W-1:0]  idl_r [NB_BUS];
  logic [REG_W:0]    act_nx_s [NB_BUS];
  logic [REG_W:0]    stl_nx_s [NB_BUS];
  logic [REG_W:0]    idl_nx_s [NB_BUS];
  logic [REG_W-1:0]  max_cur_s [NB_BUS];
  logic [REG_W-1:0]  sh_r [NB_BUS][4];
  logic [AW-1:0]     ch_s;
  logic [1:0]        idx_s;
  logic [REG_W-1:0]  rd_sel_s;

  assign hs_s  = {NB_BUS{enable}} & bus.valid & bus.ready;
  assign st_s  = {NB_BUS{enable}} & bus.valid & ~bus.ready;
  assign id_s  = {NB_BUS{enable}} & ~bus.valid & armed_r;
  assign ch_s  = bus.rd_addr >> 2;
  assign idx_s = bus.rd_addr[1:0];

  // Live counter next values; a snap restarts from zero plus this cycle's event.
  always_comb begin
    for (int i = 0; i < NB_BUS; i++) begin
      act_nx_s[i] = cnt_inc(snap ? {REG_W{1'b0}} : act_r[i], hs_s[i]);
      stl_nx_s[i] = cnt_inc(snap ? {REG_W{1'b0}} : stl_r[i], st_s[i]);
      idl_nx_s[i] = cnt_inc(snap ? {REG_W{1'b0}} : idl_r[i], id_s[i]);
      ovf_nx_s[i] = (snap ? 1'b0 : ovf_r[i]) | act_nx_s[i][REG_W] | stl_nx_s[i][REG_W]
                  | idl_nx_s[i][REG_W] | run_ovf_s[i];
    end
  end

`ifdef FRISCV_PERF_MAX_STALL_EN
  logic [REG_W-1:0] run_r [NB_BUS];
  logic [REG_W-1:0] max_r [NB_BUS];
  logic [REG_W-1:0] run_nx_s [NB_BUS];
  logic [REG_W-1:0] max_nx_s [NB_BUS];
  logic [REG_W-1:0] max_base_s [NB_BUS];
  logic [REG_W:0]   run_inc_s [NB_BUS];

  // Stall run length and its running maximum; any other enabled cycle ends the run.
  always_comb begin
    for (int i = 0; i < NB_BUS; i++) begin
      max_base_s[i] = snap ? {REG_W{1'b0}} : max_r[i];
      run_inc_s[i]  = cnt_inc(snap ? {REG_W{1'b0}} : run_r[i], st_s[i]);
      run_ovf_s[i]  = run_inc_s[i][REG_W];
      run_nx_s[i]   = run_inc_s[i][REG_W-1:0];
      max_nx_s[i]   = max_base_s[i];
      max_cur_s[i]  = max_r[i];
      if (st_s[i]) begin
        if (run_inc_s[i][REG_W-1:0] > max_base_s[i]) begin
          max_nx_s[i] = run_inc_s[i][REG_W-1:0];
        end else begin
          max_nx_s[i] = max_base_s[i];
        end
      end else if (enable) begin
        run_nx_s[i] = {REG_W{1'b0}};
      end else begin
        run_nx_s[i] = run_inc_s[i][REG_W-1:0];
      end
    end
  end

  // Run/max registers.
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      for (int i = 0; i < NB_BUS; i++) begin
        run_r[i] <= {REG_W{1'b0}};
        max_r[i] <= {REG_W{1'b0}};
      end
    end else if (srst) begin
      for (int i = 0; i < NB_BUS; i++) begin
        run_r[i] <= {REG_W{1'b0}};
        max_r[i] <= {REG_W{1'b0}};
      end
    end else begin
      for (int i = 0; i < NB_BUS; i++) begin
        run_r[i] <= run_nx_s[i];
        max_r[i] <= max_nx_s[i];
      end
    end
  end
`else
  // Without run tracking, index 3 is a constant zero.
  always_comb begin
    run_ovf_s = {NB_BUS{1'b0}};
    for (int i = 0; i < NB_BUS; i++) begin
      max_cur_s[i] = {REG_W{1'b0}};
    end
  end
`endif

  // Shadow read mux; unmatched channels contribute nothing and read as zero.
  always_comb begin
    rd_sel_s = {REG_W{1'b0}};
    for (int i = 0; i < NB_BUS; i++) begin
      rd_sel_s = rd_sel_s | ({REG_W{ch_s == AW'(i)}} & sh_r[i][idx_s]);
    end
  end

  // Live counters, shadow bank and read port registers.
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      for (int i = 0; i < NB_BUS; i++) begin
        act_r[i] <= {REG_W{1'b0}};
        stl_r[i] <= {REG_W{1'b0}};
        idl_r[i] <= {REG_W{1'b0}};
        for (int k = 0; k < 4; k++) sh_r[i][k] <= {REG_W{1'b0}};
      end
      armed_r      <= {NB_BUS{1'b0}};
      ovf_r        <= {NB_BUS{1'b0}};
      bus.overflow <= {NB_BUS{1'b0}};
      bus.rd_data  <= {REG_W{1'b0}};
      bus.rd_valid <= 1'b0;
    end else if (srst) begin
      for (int i = 0; i < NB_BUS; i++) begin
        act_r[i] <= {REG_W{1'b0}};
        stl_r[i] <= {REG_W{1'b0}};
        idl_r[i] <= {REG_W{1'b0}};
        for (int k = 0; k < 4; k++) sh_r[i][k] <= {REG_W{1'b0}};
      end
      armed_r      <= {NB_BUS{1'b0}};
      ovf_r        <= {NB_BUS{1'b0}};
      bus.overflow <= {NB_BUS{1'b0}};
      bus.rd_data  <= {REG_W{1'b0}};
      bus.rd_valid <= 1'b0;
    end else begin
      for (int i = 0; i < NB_BUS; i++) begin
        act_r[i] <= act_nx_s[i][REG_W-1:0];
        stl_r[i] <= stl_nx_s[i][REG_W-1:0];
        idl_r[i] <= idl_nx_s[i][REG_W-1:0];
        if (snap) begin
          sh_r[i][0] <= act_r[i];
          sh_r[i][1] <= stl_r[i];
          sh_r[i][2] <= idl_r[i];
          sh_r[i][3] <= max_cur_s[i];
        end
      end
      armed_r <= armed_r | hs_s;
      ovf_r   <= ovf_nx_s;
      if (snap) bus.overflow <= ovf_r;
      bus.rd_valid <= bus.rd_en;
      if (bus.rd_en) bus.rd_data <= rd_sel_s;
    end
  end

endmodule

// File: tb/tb_friscv_bus_perf_mon.sv
// Directed bench: one 32-bit saturating monitor plus 4-bit saturating and wrapping copies.
module tb_friscv_bus_perf_mon;

`ifdef FRISCV_PERF_MAX_STALL_EN
  localparam logic [31:0] MAX_BASIC = 32'd5;
  localparam logic [31:0] MAX_RUN   = 32'd3;
  localparam logic [31:0] MAX_SNAP  = 32'd1;
`else
  localparam logic [31:0] MAX_BASIC = 32'd0;
  localparam logic [31:0] MAX_RUN   = 32'd0;
  localparam logic [31:0] MAX_SNAP  = 32'd0;
`endif

  logic       aclk    = 1'b0;
  logic       aresetn = 1'b0;
  logic       srst    = 1'b0;
  logic       enable  = 1'b1;
  logic       snap    = 1'b0;
  logic [1:0] valid   = 2'b00;
  logic [1:0] ready   = 2'b00;
  logic       rd_en   = 1'b0;
  logic [2:0] rd_addr = 3'd0;

  logic [31:0] dm;
  logic [3:0]  ds, dw;
  logic        vm;
  int tests_run    = 0;
  int tests_failed = 0;

  always #5 aclk = ~aclk;

  friscv_bus_perf_mon_if #(.REG_W(32), .NB_BUS(2)) if_main ();
  friscv_bus_perf_mon_if #(.REG_W(4),  .NB_BUS(2)) if_sat ();
  friscv_bus_perf_mon_if #(.REG_W(4),  .NB_BUS(2)) if_wrap ();

  assign if_main.valid   = valid;
  assign if_main.ready   = ready;
  assign if_main.rd_en   = rd_en;
  assign if_main.rd_addr = rd_addr;
  assign if_sat.valid    = valid;
  assign if_sat.ready    = ready;
  assign if_sat.rd_en    = rd_en;
  assign if_sat.rd_addr  = rd_addr;
  assign if_wrap.valid   = valid;
  assign if_wrap.ready   = ready;
  assign if_wrap.rd_en   = rd_en;
  assign if_wrap.rd_addr = rd_addr;

  friscv_bus_perf_mon #(.REG_W(32), .NB_BUS(2), .SATURATE(1)) u_main (
    .aclk(aclk), .aresetn(aresetn), .srst(srst), .enable(enable), .snap(snap), .bus(if_main.slave));
  friscv_bus_perf_mon #(.REG_W(4), .NB_BUS(2), .SATURATE(1)) u_sat (
    .aclk(aclk), .aresetn(aresetn), .srst(srst), .enable(enable), .snap(snap), .bus(if_sat.slave));
  friscv_bus_perf_mon #(.REG_W(4), .NB_BUS(2), .SATURATE(0)) u_wrap (
    .aclk(aclk), .aresetn(aresetn), .srst(srst), .enable(enable), .snap(snap), .bus(if_wrap.slave));

  task automatic cyc();
    @(posedge aclk);
    #1;
  endtask

  task automatic drive(input logic [1:0] v, input logic [1:0] r, input int n);
    valid = v;
    ready = r;
    repeat (n) cyc();
    valid = 2'b00;
    ready = 2'b00;
  endtask

  task automatic pulse_snap();
    snap = 1'b1;
    cyc();
    snap = 1'b0;
  endtask

  task automatic do_srst();
    srst = 1'b1;
    cyc();
    srst = 1'b0;
  endtask

  task automatic rd(input logic [2:0] a);
    rd_en   = 1'b1;
    rd_addr = a;
    cyc();
    dm = if_main.rd_data;
    ds = if_sat.rd_data;
    dw = if_wrap.rd_data;
    vm = if_main.rd_valid;
    rd_en = 1'b0;
  endtask

  task automatic test_reset();
    aresetn = 1'b0;
    repeat (2) cyc();
    aresetn = 1'b1;
    cyc();
    tests_run++;
    if ({if_main.overflow, if_sat.overflow, if_wrap.overflow} !== 6'b000000) begin
      tests_failed++;
      $display("FAIL reset_overflow: got %b expected 000000",
               {if_main.overflow, if_sat.overflow, if_wrap.overflow});
    end
    for (int a = 0; a < 8; a++) begin
      rd(3'(a));
      tests_run++;
      if (vm !== 1'b1 || dm !== 32'd0 || ds !== 4'd0 || dw !== 4'd0) begin
        tests_failed++;
        $display("FAIL reset_read addr%0d: got valid=%b data=%0d/%0d/%0d expected valid=1 data=0",
                 a, vm, dm, ds, dw);
      end
    end
    cyc();
    tests_run++;
    if (if_main.rd_valid !== 1'b0) begin
      tests_failed++;
      $display("FAIL reset_rd_valid_idle: got %b expected 0", if_main.rd_valid);
    end
  endtask

  task automatic test_basic();
    logic [31:0] e [4];
    e = '{32'd4, 32'd5, 32'd2, MAX_BASIC};
    do_srst();
    drive(2'b00, 2'b00, 3);
    drive(2'b01, 2'b01, 4);
    drive(2'b01, 2'b00, 5);
    drive(2'b00, 2'b00, 2);
    pulse_snap();
    for (int a = 0; a < 4; a++) begin
      rd(3'(a));
      tests_run++;
      if (dm !== e[a] || vm !== 1'b1) begin
        tests_failed++;
        $display("FAIL basic addr%0d: got %0d (valid %b) expected %0d", a, dm, vm, e[a]);
      end
    end
  endtask

  task automatic test_snap_event();
    do_srst();
    drive(2'b01, 2'b01, 3);
    valid = 2'b01; ready = 2'b01; snap = 1'b1;
    cyc();
    snap = 1'b0; valid = 2'b00; ready = 2'b00;
    rd(3'd0);
    tests_run++;
    if (dm !== 32'd3) begin
      tests_failed++;
      $display("FAIL snap_excludes_event: got %0d expected 3", dm);
    end
    drive(2'b01, 2'b01, 1);
    snap = 1'b1; rd_en = 1'b1; rd_addr = 3'd0;
    cyc();
    dm = if_main.rd_data;
    snap = 1'b0; rd_en = 1'b0;
    tests_run++;
    if (dm !== 32'd3) begin
      tests_failed++;
      $display("FAIL read_during_snap: got %0d expected 3", dm);
    end
    rd(3'd0);
    tests_run++;
    if (dm !== 32'd2) begin
      tests_failed++;
      $display("FAIL snap_keeps_event: got %0d expected 2", dm);
    end
  endtask

  task automatic test_saturate();
    do_srst();
    drive(2'b01, 2'b01, 20);
    pulse_snap();
    tests_run++;
    if (if_main.overflow !== 2'b00 || if_sat.overflow !== 2'b01 || if_wrap.overflow !== 2'b01) begin
      tests_failed++;
      $display("FAIL overflow_flags: got main=%b sat=%b wrap=%b expected 00/01/01",
               if_main.overflow, if_sat.overflow, if_wrap.overflow);
    end
    rd(3'd0);
    tests_run++;
    if (dm !== 32'd20 || ds !== 4'd15 || dw !== 4'd4) begin
      tests_failed++;
      $display("FAIL overflow_active: got %0d/%0d/%0d expected 20/15/4", dm, ds, dw);
    end
    pulse_snap();
    tests_run++;
    if (if_sat.overflow !== 2'b00 || if_wrap.overflow !== 2'b00) begin
      tests_failed++;
      $display("FAIL overflow_cleared: got sat=%b wrap=%b expected 00/00",
               if_sat.overflow, if_wrap.overflow);
    end
  endtask

  task automatic test_enable();
    logic [31:0] e [4];
    e = '{32'd2, 32'd0, 32'd0, 32'd0};
    do_srst();
    drive(2'b01, 2'b01, 1);
    enable = 1'b0;
    drive(2'b01, 2'b00, 10);
    enable = 1'b1;
    drive(2'b01, 2'b01, 1);
    pulse_snap();
    for (int a = 0; a < 4; a++) begin
      rd(3'(a));
      tests_run++;
      if (dm !== e[a]) begin
        tests_failed++;
        $display("FAIL enable_freeze addr%0d: got %0d expected %0d", a, dm, e[a]);
      end
    end
    drive(2'b01, 2'b01, 2);
    do_srst();
    for (int a = 0; a < 8; a++) begin
      rd(3'(a));
      tests_run++;
      if (dm !== 32'd0 || vm !== 1'b1) begin
        tests_failed++;
        $display("FAIL srst_clear addr%0d: got %0d (valid %b) expected 0", a, dm, vm);
      end
    end
  endtask

  task automatic test_max_stall();
    do_srst();
    drive(2'b01, 2'b00, 2);
    drive(2'b01, 2'b01, 1);
    drive(2'b01, 2'b00, 3);
    drive(2'b01, 2'b01, 1);
    drive(2'b01, 2'b00, 1);
    pulse_snap();
    rd(3'd1);
    tests_run++;
    if (dm !== 32'd6) begin
      tests_failed++;
      $display("FAIL run_stall_total: got %0d expected 6", dm);
    end
    rd(3'd3);
    tests_run++;
    if (dm !== MAX_RUN) begin
      tests_failed++;
      $display("FAIL max_stall_run: got %0d expected %0d", dm, MAX_RUN);
    end
    valid = 2'b01; ready = 2'b00; snap = 1'b1;
    cyc();
    snap = 1'b0;
    drive(2'b01, 2'b01, 1);
    pulse_snap();
    rd(3'd3);
    tests_run++;
    if (dm !== MAX_SNAP) begin
      tests_failed++;
      $display("FAIL max_stall_snap_cycle: got %0d expected %0d", dm, MAX_SNAP);
    end
  endtask

  task automatic test_channels();
    logic [31:0] e [8];
    e = '{32'd3, 32'd0, 32'd0, 32'd0, 32'd0, 32'd3, 32'd0, MAX_RUN};
    do_srst();
    drive(2'b11, 2'b01, 3);
    pulse_snap();
    for (int a = 0; a < 8; a++) begin
      rd(3'(a));
      tests_run++;
      if (dm !== e[a]) begin
        tests_failed++;
        $display("FAIL channel addr%0d: got %0d expected %0d", a, dm, e[a]);
      end
    end
  endtask

  task automatic test_async_reset();
    do_srst();
    drive(2'b01, 2'b01, 20);
    pulse_snap();
    drive(2'b01, 2'b01, 1);
    #2;
    aresetn = 1'b0;
    #1;
    tests_run++;
    if (if_sat.overflow !== 2'b00 || if_main.rd_valid !== 1'b0) begin
      tests_failed++;
      $display("FAIL async_reset_immediate: got overflow=%b rd_valid=%b expected 00/0",
               if_sat.overflow, if_main.rd_valid);
    end
    cyc();
    aresetn = 1'b1;
    cyc();
    rd(3'd0);
    tests_run++;
    if (dm !== 32'd0 || ds !== 4'd0) begin
      tests_failed++;
      $display("FAIL async_reset_shadow: got %0d/%0d expected 0/0", dm, ds);
    end
    drive(2'b00, 2'b00, 2);
    drive(2'b01, 2'b01, 1);
    drive(2'b00, 2'b00, 2);
    pulse_snap();
    rd(3'd0);
    tests_run++;
    if (dm !== 32'd1) begin
      tests_failed++;
      $display("FAIL rearm_active: got %0d expected 1", dm);
    end
    rd(3'd2);
    tests_run++;
    if (dm !== 32'd2) begin
      tests_failed++;
      $display("FAIL rearm_idle: got %0d expected 2", dm);
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_snap_event();
    test_saturate();
    test_enable();
    test_max_stall();
    test_channels();
    test_async_reset();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/friscv_bus_perf_mon.md
Name: friscv_bus_perf_mon

Overview:
- Per-channel bus activity monitor for NB_BUS valid/ready interfaces.
- Counts handshake (active), stall and idle cycles in live counters, with optional maximum stall-run tracking.
- Snapshot pulse atomically moves live values into a shadow bank and restarts measurement.
- Shadow bank is read through a simple 1-cycle-latency register port by the CSR/debug logic.

Parameters:
- REG_W, 32, width of every counter and of rd_data (>=2).
- NB_BUS, 2, number of monitored channels (>=1).
- SATURATE, 1, 1 = counters stick at all-ones; 0 = counters wrap to 0.

Ports:
- aclk  in  1  clock.
- aresetn  in  1  asynchronous active-low reset.
- srst  in  1  synchronous active-high reset.
- enable  in  1  1 = live counters update; 0 = live state frozen.
- snap  in  1  pulse: copy live to shadow, restart live.
- valid  in  NB_BUS  per-channel valid.
- ready  in  NB_BUS  per-channel ready.
- rd_en  in  1  read request.
- rd_addr  in  $clog2(NB_BUS)+2  {channel, index}.
- rd_data  out  REG_W  shadow counter value.
- rd_valid  out  1  rd_data qualifier.
- overflow  out  NB_BUS  shadow sticky overflow per channel.

Behaviour:
- Reset (aresetn low or srst high): all live counters, armed flags, live overflow, shadow bank, overflow, rd_data and rd_valid go to 0. srst has the same effect synchronously.
- Per channel i, each cycle with enable=1:
  - active += 1 when valid & ready.
  - stall += 1 when valid & !ready.
  - idle += 1 when !valid and armed[i]=1.
  - armed[i] sets on the first handshake and stays set until reset. A handshake cycle itself is counted as active, not idle.
- enable=0: no counter, armed flag or run-length updates; snap and reads still operate.
- Overflow:
  - SATURATE=1: a counter at 2^REG_W-1 holds its value on increment and sets the live overflow bit for its channel.
  - SATURATE=0: the counter wraps to 0 and sets the live overflow bit.
  - Live overflow is sticky until snap or reset.
- snap=1 (single cycle), for every channel:
  - shadow <= live values as at the start of the cycle; overflow <= live overflow.
  - Live counters restart from 0 plus that cycle's increment (an event in the snap cycle is never lost).
  - Live overflow clears, unless that same cycle's increment overflows.
  - armed flags are preserved.
- Read port:
  - rd_en in cycle N gives rd_valid=1 and rd_data in cycle N+1. rd_valid is low otherwise.
  - Address = channel*4 + index. Index 0 = active, 1 = stall, 2 = idle, 3 = max stall run.
  - A channel >= NB_BUS returns 0 with rd_valid=1.
  - A read in the same cycle as snap returns the pre-snap shadow value.
- Back-to-back reads are allowed every cycle; there is no backpressure on the read port.
- aresetn mid-measurement clears everything immediately. The first post-reset handshake re-arms idle counting.

Optional Feature:
- Macro: FRISCV_PERF_MAX_STALL_EN.
- Defined:
  - Per channel, a run counter increments on each valid & !ready cycle (when enabled) and clears on any other enabled cycle.
  - max_stall <= run+1 whenever run+1 > max_stall. Both counters follow the same saturate/wrap rule.
  - snap copies max_stall to shadow index 3 and clears run and max_stall. A stall in the snap cycle starts both at 1.
- Undefined: no run/max logic is instantiated and index 3 always reads 0.

Test Plan:
- Reset, then read all addresses -> every rd_data=0, rd_valid one cycle after each rd_en, overflow=0.
- Ch0: 3 idle cycles (unarmed), 4 handshakes, 5 stalls, 2 idle; snap; read ch0 -> active=4, stall=5, idle=2; max stall=5 with macro, 0 without.
- Handshake on the snap cycle, then 1 more handshake, then snap -> first shadow excludes the snap-cycle event; second shadow active=2.
- REG_W=4, SATURATE=1, 20 handshakes, snap -> active=15, overflow[0]=1. With SATURATE=0 -> active=4, overflow[0]=1.
- enable=0 during 10 stall cycles between 2 handshakes -> stall=0, active=2. srst mid-run -> all reads 0.
- NB_BUS=2: ch1 stalls 3 while ch0 handshakes 3; read addr 1 -> 0, addr 4 -> 0, addr 5 -> 3 (channel independence).
